// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock, with a cached key schedule
// Ports: clk/rst (sync, active-high); in_valid/in_ready + ciphertext/key accept a block (in_ready only in IDLE);
// out_valid/out_ready + plaintext return the result (held until accepted); busy is high outside IDLE.
module aes128_decrypt_iter #(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  typedef logic [0:255][7:0] tbl_t;
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;
  localparam tbl_t SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // The inverse S-box is derived from the forward table at elaboration so the two can never disagree.
  function automatic tbl_t invert(input tbl_t t);
    tbl_t r;
    r = '0;
    for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
    return r;
  endfunction
  localparam tbl_t INV_SBOX = invert(SBOX);
  localparam logic [0:10][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = INV_SBOX[s[127-8*((((n/4) - (n%4) + 4) % 4)*4 + n%4) -: 8]];
    return r;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[127-8*(4*c+i) -: 8];
        x2[i] = xt(a[i]);
        x4[i] = xt(x2[i]);
        x8[i] = xt(x4[i]);
      end
      for (int i = 0; i < 4; i++)
        r[127-8*(4*c+i) -: 8] = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4]) ^
                                (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4]) ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
    return r;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  state_t       state_q;
  logic [3:0]   cnt_q;
  logic         cache_q, ov_q;
  logic [127:0] st_q, pt_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] iss, st_d;
  logic         hit;
  assign in_ready  = state_q == IDLE;
  assign busy      = !in_ready;
  assign out_valid = ov_q;
  assign plaintext = pt_q;
  // rk_q[0] doubles as the cached key: it only changes when a miss starts a fresh expansion.
  assign hit  = CACHE_KEY && cache_q && key == rk_q[0];
  assign iss  = inv_sub_shift(st_q);
  assign st_d = inv_mix(iss ^ rk_q[cnt_q]);
  always_ff @(posedge clk)
    if (state_q == IDLE && in_valid && !hit) rk_q[0] <= key;
    else if (state_q == KEYEXP) rk_q[cnt_q] <= next_key(rk_q[cnt_q - 4'd1], RCON[cnt_q]);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cache_q <= 1'b0;
      ov_q    <= 1'b0;
      pt_q    <= '0;
      st_q    <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          st_q    <= ciphertext;
          cnt_q   <= 4'd1;
          cache_q <= hit;
          state_q <= hit ? INIT : KEYEXP;
        end
        KEYEXP: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            cache_q <= 1'b1;
            state_q <= INIT;
          end
        end
        INIT: begin
          st_q    <= st_q ^ rk_q[10];
          cnt_q   <= 4'd9;
          state_q <= ROUND;
        end
        ROUND: if (cnt_q != 4'd0) begin
          st_q  <= st_d;
          cnt_q <= cnt_q - 4'd1;
        end else begin
          pt_q    <= iss ^ rk_q[0];
          ov_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          ov_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: known-answer, cache, backpressure, reset and random round-trip checks
module tb_aes128_decrypt_iter;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, sel;
  logic [127:0] ciphertext, key;
  logic ir1, ov1, busy1, ir0, ov0, busy0;
  logic [127:0] pt1, pt0;
  logic m_ir, m_ov, m_busy;
  logic [127:0] m_pt;
  int n_vec = 0, n_err = 0;
  logic mc_valid;
  logic [127:0] mc_key;
  logic [7:0] sb [256];
  typedef struct {
    logic [127:0] k, c, p;
    int lat, hold;
  } vec_t;
  vec_t tv [5];
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes128_decrypt_iter #(.CACHE_KEY(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir1), .ciphertext(ciphertext), .key(key),
    .out_valid(ov1), .out_ready(out_ready), .plaintext(pt1), .busy(busy1));
  aes128_decrypt_iter #(.CACHE_KEY(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir0), .ciphertext(ciphertext), .key(key),
    .out_valid(ov0), .out_ready(out_ready), .plaintext(pt0), .busy(busy0));

  assign m_ir   = sel ? ir0 : ir1;
  assign m_ov   = sel ? ov0 : ov1;
  assign m_busy = sel ? busy0 : busy1;
  assign m_pt   = sel ? pt0 : pt1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference encryptor straight from the cipher definition, on a byte-array state.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [31:0] x;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {x[23:0], x[31:24]};
        x = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[4*(((n/4) + (n%4)) % 4) + n%4]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[4*c+q] = (rd == 10) ? t[4*c+q] :
                     gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03) ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One block: submit, scramble inputs while busy, measure latency, optionally stall the output.
  task automatic xfer(input string nm, input logic [127:0] k, input logic [127:0] c, input logic [127:0] p_exp,
                      input int lat_exp, input int hold);
    int t, lat;
    logic busy_ok;
    logic [127:0] p;
    out_ready = (hold == 0);
    key = k;
    ciphertext = c;
    in_valid = 1'b1;
    t = 0;
    while (!m_ir && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    busy_ok = 1'b1;
    lat = 0;
    while (!m_ov && lat < 40) begin
      busy_ok = busy_ok & m_busy & !m_ir;
      @(posedge clk); #1;
      lat++;
      in_valid = 1'($urandom);
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    p = m_pt;
    chk({nm, " latency"}, 256'(lat), 256'(lat_exp));
    chk({nm, " busy"}, 256'(busy_ok), 256'(1'b1));
    chk({nm, " plaintext"}, 256'(p), 256'(p_exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold ov/ir/pt"}, 256'({m_ov, m_ir, m_pt}), 256'({1'b1, 1'b0, p}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " release ov/ir/busy"}, 256'({m_ov, m_ir, m_busy}), 256'({1'b0, 1'b1, 1'b0}));
    if (!sel) begin
      mc_valid = 1'b1;
      mc_key = k;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p;
    logic ov_seen;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
    tv[0] = '{k: C1K, c: C1C, p: C1P, lat: 21, hold: 0};
    tv[1] = '{k: C1K, c: C1C, p: C1P, lat: 11, hold: 5};
    tv[2] = '{k: BK,  c: BC,  p: BP,  lat: 21, hold: 0};
    tv[3] = '{k: BK,  c: BC,  p: BP,  lat: 11, hold: 2};
    tv[4] = '{k: C1K, c: C1C, p: C1P, lat: 21, hold: 0};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sel = 1'b0;
    key = '0;
    ciphertext = '0;
    mc_valid = 1'b0;
    mc_key = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset cached", 256'({ov1, ir1, busy1, pt1}), 256'({1'b0, 1'b1, 1'b0, 128'h0}));
    chk("reset uncached", 256'({ov0, ir0, busy0, pt0}), 256'({1'b0, 1'b1, 1'b0, 128'h0}));
    for (int i = 0; i < 5; i++) xfer($sformatf("kat%0d", i), tv[i].k, tv[i].c, tv[i].p, tv[i].lat, tv[i].hold);
    sel = 1'b1;
    xfer("nocache first", C1K, C1C, C1P, 21, 0);
    xfer("nocache repeat", C1K, C1C, C1P, 21, 0);
    sel = 1'b0;
    key = C1K;
    ciphertext = C1C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midop busy", 256'({ov1, busy1}), 256'({1'b0, 1'b1}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mc_valid = 1'b0;
    chk("midop reset state", 256'({ov1, ir1, busy1, pt1}), 256'({1'b0, 1'b1, 1'b0, 128'h0}));
    ov_seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | ov1;
    end
    chk("midop no output", 256'(ov_seen), 256'(1'b0));
    xfer("post-reset", C1K, C1C, C1P, 21, 0);
    k = '0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0 || $urandom_range(2) != 0) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      xfer($sformatf("rand%0d", i), k, aes_enc(p, k), p, (mc_valid && k == mc_key) ? 11 : 21, $urandom_range(2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
